// File: rtl/fxdiv_pkg.sv
// Shared definitions for the byte-serial fixed-point divider controller
// and its iterative datapath: FSM state encoding and width helpers.
package fxdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fxdivState_t;

    // Width of the load byte counter; it must be able to hold the saturated
    // value WA/8 + WB/8, which is one past the last byte index.
    function automatic int cntWidth(input int wa, input int wb);
        return $clog2(wa / 8 + wb / 8 + 1);
    endfunction

    // Width of the iteration counter; it is loaded with WA+FRAC and counts
    // down to one, so it needs to hold WA+FRAC itself.
    function automatic int iterWidth(input int wa, input int frac);
        return $clog2(wa + frac + 1);
    endfunction

endpackage

// File: rtl/fxdiv_core.sv
// Restoring shift/subtract divider producing one quotient bit per cycle.
// The numerator {a, FRAC zeros} is shifted in MSB first. q_valid is high
// during the last iteration, and q_raw then carries the complete quotient,
// so the controller captures the result on the same edge as that iteration.
module fxdiv_core
    import fxdiv_pkg::*;
#(
    parameter int WA   = 32,
    parameter int WB   = 16,
    parameter int FRAC = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WA-1:0]        a,
    input  logic [WB-1:0]        b,
    output logic                 busy,
    output logic [WA+FRAC-1:0]   q_raw,
    output logic                 q_valid
);

    localparam int N  = WA + FRAC;
    localparam int IW = iterWidth(WA, FRAC);

    logic [N-1:0]  r_num;
    logic [WB:0]   r_rem;
    logic [WB-1:0] r_b;
    logic [N-2:0]  r_quo;
    logic [IW-1:0] r_iter;
    logic          r_busy;

    logic [WB:0]   w_shift;
    logic          w_ge;
    logic [WB:0]   w_remNext;

    // One restoring step: shift the next numerator bit into the remainder,
    // then subtract the divisor when it fits. The remainder's top bit is
    // always zero after a restore, but it is still folded into the compare
    // so that any remainder of 2^WB or more counts as "fits".
    always_comb begin
        w_shift   = {r_rem[WB-1:0], r_num[N-1]};
        w_ge      = r_rem[WB] | (w_shift >= {1'b0, r_b});
        w_remNext = w_ge ? (w_shift - {1'b0, r_b}) : w_shift;
    end

    // The final quotient bit comes straight from this cycle's compare.
    assign q_raw   = {r_quo, w_ge};
    assign q_valid = r_busy && (r_iter == IW'(1));
    assign busy    = r_busy;

    // Start captures the operands and loads the iteration counter. Each
    // busy cycle then retires one quotient bit, until the counter hits one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_num  <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_quo  <= '0;
            r_iter <= '0;
            r_busy <= 1'b0;
        end else if (start && !r_busy) begin
            r_num          <= '0;
            r_num[N-1 -: WA] <= a;
            r_rem          <= '0;
            r_b            <= b;
            r_quo          <= '0;
            r_iter         <= IW'(N);
            r_busy         <= 1'b1;
        end else if (r_busy) begin
            r_num  <= r_num << 1;
            r_rem  <= w_remNext;
            r_quo  <= {r_quo[N-3:0], w_ge};
            r_iter <= r_iter - IW'(1);
            r_busy <= (r_iter != IW'(1));
        end
    end

endmodule

// File: rtl/fixed_divider_seq_ctrl.sv
// Byte-serial fixed-point divider controller: loads A and B one byte per
// set/unlock handshake, runs Q = (A << FRAC) / B in fxdiv_core, and shows
// the quotient a byte at a time. Build option FXDIV_SAT_EN: when defined,
// an overflowing quotient saturates to all ones instead of wrapping.
module fixed_divider_seq_ctrl
    import fxdiv_pkg::*;
#(
    parameter int WA   = 32,
    parameter int WB   = 16,
    parameter int FRAC = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              inA,
    input  logic                    set,
    input  logic                    unlock,
    input  logic                    init,
    input  logic [$clog2(WA/8)-1:0] select,
    output logic [7:0]              out,
    output logic                    busy,
    output logic                    done,
    output logic                    div_zero,
    output logic                    ovf
);

    localparam int NA   = WA / 8;
    localparam int NB   = WB / 8;
    localparam int NTOT = NA + NB;
    localparam int CW   = cntWidth(WA, WB);
    localparam int SELW = $clog2(WA / 8);
    localparam int N    = WA + FRAC;

    fxdivState_t r_state;
    fxdivState_t w_nextState;

    logic          r_lock;
    logic [CW-1:0] r_cnt;
    logic [WA-1:0] r_a;
    logic [WB-1:0] r_b;
    logic [WA-1:0] r_quo;
    logic          r_done;
    logic          r_divZero;
    logic          r_ovf;

    logic          w_accept;
    logic          w_start;
    logic          w_bZero;
    logic          w_coreBusy;
    logic          w_coreValid;
    logic [N-1:0]  w_qRaw;
    logic          w_ovf;
    logic [WA-1:0] w_quoNext;

    assign w_accept = set && !r_lock && (r_state != ST_RUN);
    assign w_start  = init && (r_state != ST_RUN);
    assign w_bZero  = (r_b == '0);

    fxdiv_core #(
        .WA   (WA),
        .WB   (WB),
        .FRAC (FRAC)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .start   (w_start && !w_bZero),
        .a       (r_a),
        .b       (r_b),
        .busy    (w_coreBusy),
        .q_raw   (w_qRaw),
        .q_valid (w_coreValid)
    );

    // State register for the load/run/done sequence.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A zero divisor skips the datapath entirely and lands in DONE on the
    // init edge; otherwise RUN lasts until the core's last iteration.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_nextState = w_bZero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_coreValid) begin
                    w_nextState = ST_DONE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Byte loader: an accepted byte goes to the slot the counter points at
    // and then locks until unlock. Once all slots are full, bytes are
    // dropped but still lock. A start rewinds the counter for the next load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_lock <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_accept && (r_cnt < CW'(NTOT))) begin
                for (int i = 0; i < NA; i++) begin
                    if (r_cnt == CW'(i)) begin
                        r_a[8*i +: 8] <= inA;
                    end
                end
                for (int i = 0; i < NB; i++) begin
                    if (r_cnt == CW'(NA + i)) begin
                        r_b[8*i +: 8] <= inA;
                    end
                end
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) begin
                r_lock <= 1'b1;
            end else if (unlock) begin
                r_lock <= 1'b0;
            end
        end
    end

    // Overflow means the raw quotient has bits above WA. The quotient
    // register either saturates or keeps the low WA bits, depending on the build.
    always_comb begin
        w_ovf = ((w_qRaw >> WA) != '0);
`ifdef FXDIV_SAT_EN
        w_quoNext = w_ovf ? '1 : w_qRaw[WA-1:0];
`else
        w_quoNext = w_qRaw[WA-1:0];
`endif
    end

    // Result flags and quotient: cleared on start, filled in either at the
    // start itself (zero divisor) or when the core finishes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_quo     <= '0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_start) begin
            r_done    <= w_bZero;
            r_divZero <= w_bZero;
            r_ovf     <= 1'b0;
            if (w_bZero) begin
                r_quo <= '1;
            end
        end else if ((r_state == ST_RUN) && w_coreValid) begin
            r_done <= 1'b1;
            r_ovf  <= w_ovf;
            r_quo  <= w_quoNext;
        end
    end

    // Byte-select mux on the registered quotient, so out is glitch-free
    // with respect to the running division.
    always_comb begin
        out = '0;
        for (int i = 0; i < NA; i++) begin
            if (select == SELW'(i)) begin
                out = r_quo[8*i +: 8];
            end
        end
    end

    assign busy     = w_coreBusy;
    assign done     = r_done;
    assign div_zero = r_divZero;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_fixed_divider_seq_ctrl.sv
// Self-checking bench for fixed_divider_seq_ctrl at WA=32, WB=16, FRAC=16.
// Honours FXDIV_SAT_EN for the expected quotient of overflowing divisions.
module tb_fixed_divider_seq_ctrl;

    localparam int WA   = 32;
    localparam int WB   = 16;
    localparam int FRAC = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] inA;
    logic       set;
    logic       unlock;
    logic       init;
    logic [1:0] select;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       divZero;
    logic       ovf;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] expQ;
        logic        expOvf;
        logic        expDz;
        int          expCycles;
    } vector_t;

    vector_t vecs[8];

`ifdef FXDIV_SAT_EN
    localparam logic [31:0] Q_OVF_A = 32'hFFFF_FFFF;
    localparam logic [31:0] Q_OVF_B = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] Q_OVF_A = 32'h0000_0000;
    localparam logic [31:0] Q_OVF_B = 32'h0001_0000;
`endif

    fixed_divider_seq_ctrl #(
        .WA   (WA),
        .WB   (WB),
        .FRAC (FRAC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .inA      (inA),
        .set      (set),
        .unlock   (unlock),
        .init     (init),
        .select   (select),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .div_zero (divZero),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    // One comparison; a mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Full set/unlock handshake for one byte.
    task automatic applyStimulus(input logic [7:0] value);
        @(negedge clock);
        inA = value;
        set = 1'b1;
        @(negedge clock);
        set    = 1'b0;
        unlock = 1'b1;
        @(negedge clock);
        unlock = 1'b0;
    endtask

    task automatic loadOperands(input logic [31:0] a, input logic [15:0] b);
        for (int i = 0; i < 4; i++) applyStimulus(a[8*i +: 8]);
        for (int i = 0; i < 2; i++) applyStimulus(b[8*i +: 8]);
    endtask

    // Pulse init for one edge; returns half a cycle after that edge.
    task automatic startDiv();
        @(negedge clock);
        init = 1'b1;
        @(negedge clock);
        init = 1'b0;
    endtask

    // Counts cycles until done and how many of them showed busy; bounded.
    // reinitAt >= 0 pulses init again at that cycle of the run.
    task automatic waitDone(input int reinitAt, output int cyc, output int busyCyc);
        cyc     = 0;
        busyCyc = 0;
        while (!done && cyc < 200) begin
            if (busy) busyCyc++;
            init = (cyc == reinitAt);
            @(negedge clock);
            cyc++;
        end
        init = 1'b0;
    endtask

    task automatic checkQuotient(input string tag, input logic [31:0] expQ);
        for (int i = 0; i < 4; i++) begin
            select = 2'(i);
            #1;
            checkOutput($sformatf("%s out[%0d]", tag, i), {24'd0, out}, {24'd0, expQ[8*i +: 8]});
        end
    endtask

    task automatic runCase(input string tag, input logic [31:0] a, input logic [15:0] b,
                           input int reinitAt, input logic [31:0] expQ, input logic expOvf,
                           input logic expDz, input int expCycles);
        int cyc;
        int busyCyc;
        loadOperands(a, b);
        startDiv();
        waitDone(reinitAt, cyc, busyCyc);
        checkOutput({tag, " cycles"}, 32'(cyc), 32'(expCycles));
        checkOutput({tag, " busyCycles"}, 32'(busyCyc), 32'(expCycles));
        checkOutput({tag, " done"}, {31'd0, done}, 32'd1);
        checkOutput({tag, " ovf"}, {31'd0, ovf}, {31'd0, expOvf});
        checkOutput({tag, " divZero"}, {31'd0, divZero}, {31'd0, expDz});
        checkQuotient(tag, expQ);
    endtask

    initial begin
        reset  = 1'b1;
        inA    = 8'h00;
        set    = 1'b0;
        unlock = 1'b0;
        init   = 1'b0;
        select = 2'd0;

        vecs[0] = '{32'h0000_0006, 16'h0004, 32'h0001_8000, 1'b0, 1'b0, 48};
        vecs[1] = '{32'h0001_0000, 16'h0001, Q_OVF_A,       1'b1, 1'b0, 48};
        vecs[2] = '{32'h0000_0005, 16'h0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0};
        vecs[3] = '{32'h0000_0001, 16'h0003, 32'h0000_5555, 1'b0, 1'b0, 48};
        vecs[4] = '{32'hFFFF_FFFF, 16'hFFFF, Q_OVF_B,       1'b1, 1'b0, 48};
        vecs[5] = '{32'h0000_0064, 16'h0007, 32'h000E_4924, 1'b0, 1'b0, 48};
        vecs[6] = '{32'h0000_0000, 16'h0005, 32'h0000_0000, 1'b0, 1'b0, 48};
        vecs[7] = '{32'h0000_FFFF, 16'h0001, 32'hFFFF_0000, 1'b0, 1'b0, 48};

        repeat (2) @(negedge clock);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset divZero", {31'd0, divZero}, 32'd0);
        checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
        checkQuotient("reset", 32'h0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            runCase($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, -1, vecs[v].expQ,
                    vecs[v].expOvf, vecs[v].expDz, vecs[v].expCycles);
        end

        // Held set writes only once; set+unlock together while unlocked still locks.
        @(negedge clock);
        set = 1'b1;
        inA = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            inA = 8'h22 + 8'(i);
        end
        @(negedge clock);
        set    = 1'b0;
        unlock = 1'b1;
        @(negedge clock);
        unlock = 1'b0;
        set    = 1'b1;
        unlock = 1'b1;
        inA    = 8'h33;
        @(negedge clock);
        unlock = 1'b0;
        inA    = 8'h44;
        @(negedge clock);
        set    = 1'b0;
        unlock = 1'b1;
        @(negedge clock);
        unlock = 1'b0;
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h99);
        begin
            int cyc;
            int busyCyc;
            startDiv();
            waitDone(-1, cyc, busyCyc);
            checkOutput("lock cycles", 32'(cyc), 32'd48);
            checkOutput("lock ovf", {31'd0, ovf}, 32'd0);
            checkQuotient("lock", 32'h3311_0000);
        end

        // A second init during RUN is ignored.
        runCase("reinit", 32'h0000_0006, 16'h0004, 10, 32'h0001_8000, 1'b0, 1'b0, 48);

        // Reset mid-run aborts at once, then a fresh division still works.
        loadOperands(32'h0000_0064, 16'h0007);
        startDiv();
        repeat (20) @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midReset busy", {31'd0, busy}, 32'd0);
        checkOutput("midReset done", {31'd0, done}, 32'd0);
        checkQuotient("midReset", 32'h0);
        @(negedge clock);
        reset = 1'b0;
        runCase("afterReset", 32'h0000_0006, 16'h0004, -1, 32'h0001_8000, 1'b0, 1'b0, 48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
